// File: rtl/inst_fetch.sv
// Byte-serial instruction fetcher: reads opcode then N operand bytes from
// byte-wide program memory (single outstanding request) and presents
// opc/opl/inst_pc to the decoder under inst_valid/inst_ready.
// Ports: clk/rst (sync, active-high); mem_req/mem_addr/mem_valid/mem_rdata
// memory side; opc/opl/inst_pc/inst_valid/inst_ready decode side;
// jmp_en/jmp_addr redirect from execute.
// Optional macro FETCH_ILLEGAL_TRAP_EN: opc[7]=1 traps (extra output ill).
module inst_fetch #(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_valid,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    opc,
  output logic [63:0]   opl,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr
`ifdef FETCH_ILLEGAL_TRAP_EN
  ,
  output logic          ill
`endif
);

  typedef enum logic [2:0] {
    S_OPC,
    S_OWAIT,
    S_OPL,
    S_LWAIT,
    S_HOLD
`ifdef FETCH_ILLEGAL_TRAP_EN
    ,
    S_TRAP
`endif
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [2:0]    cnt, cnt_n;
  logic          drop, drop_n;
  logic [7:0]    opc_n;
  logic [63:0]   opl_n;
  logic [AW-1:0] inst_pc_n;
  logic          inst_valid_n;
  logic [3:0]    len;

  // Operand byte count selected by the two low opcode bits.
  function automatic logic [3:0] operand_len(input logic [7:0] o);
    if (o[0])      return 4'd5;
    else if (o[1]) return 4'd8;
    else           return 4'd2;
  endfunction

  assign len      = operand_len(opc);
  assign mem_addr = pc;

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign ill = (state == S_TRAP);
`endif

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    cnt_n        = cnt;
    drop_n       = drop;
    opc_n        = opc;
    opl_n        = opl;
    inst_pc_n    = inst_pc;
    inst_valid_n = inst_valid;
    mem_req      = 1'b0;

    // A response to a request abandoned by a jump is swallowed here.
    if (drop && mem_valid) drop_n = 1'b0;

    case (state)
      S_OPC: begin
        if (!drop) begin
          mem_req = 1'b1;
          state_n = S_OWAIT;
        end
      end
      S_OWAIT: begin
        if (mem_valid) begin
          opc_n     = mem_rdata;
          inst_pc_n = pc;
          opl_n     = '0;
          cnt_n     = '0;
          pc_n      = pc + AW'(1);
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (mem_rdata[7]) begin
            state_n      = S_TRAP;
            inst_valid_n = 1'b1;
          end else begin
            state_n = S_OPL;
          end
`else
          state_n = S_OPL;
`endif
        end
      end
      S_OPL: begin
        mem_req = 1'b1;
        state_n = S_LWAIT;
      end
      S_LWAIT: begin
        if (mem_valid) begin
          opl_n[{cnt, 3'b000} +: 8] = mem_rdata;
          pc_n  = pc + AW'(1);
          cnt_n = cnt + 3'd1;
          if (({1'b0, cnt} + 4'd1) == len) begin
            state_n      = S_HOLD;
            inst_valid_n = 1'b1;
          end else begin
            state_n = S_OPL;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          inst_valid_n = 1'b0;
          state_n      = S_OPC;
        end
      end
      default: ;
    endcase

    // Redirect overrides everything. A request still in flight (or an
    // already-pending discard) must have its response dropped later.
    if (jmp_en) begin
      pc_n         = jmp_addr;
      inst_valid_n = 1'b0;
      state_n      = S_OPC;
      mem_req      = 1'b0;
      drop_n       = !mem_valid &&
                     (drop || state == S_OWAIT || state == S_LWAIT);
    end

    if (rst) mem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OPC;
      pc         <= RESET_PC;
      cnt        <= '0;
      drop       <= 1'b0;
      opc        <= '0;
      opl        <= '0;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      cnt        <= cnt_n;
      drop       <= drop_n;
      opc        <= opc_n;
      opl        <= opl_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= inst_valid_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: RESET_PC = 0, variable-latency memory
  logic        rst = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  opc;
  logic [63:0] opl;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        jmp_en = 1'b0;
  logic [15:0] jmp_addr = 16'h0000;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic        ill;
  logic        ill1;
`endif

  // DUT 1: RESET_PC = 0xFFFF, 1-cycle memory
  logic        rst1 = 1'b1;
  logic        mem1_req;
  logic [15:0] mem1_addr;
  logic        mem1_valid = 1'b0;
  logic [7:0]  mem1_rdata = 8'h00;
  logic [7:0]  opc1;
  logic [63:0] opl1;
  logic [15:0] inst_pc1;
  logic        inst_valid1;
  logic        rdy1 = 1'b0;

  inst_fetch #(.AW(16), .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .opc(opc), .opl(opl),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr)
`ifdef FETCH_ILLEGAL_TRAP_EN
    , .ill(ill)
`endif
  );

  inst_fetch #(.AW(16), .RESET_PC(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst1), .mem_req(mem1_req), .mem_addr(mem1_addr),
    .mem_valid(mem1_valid), .mem_rdata(mem1_rdata), .opc(opc1), .opl(opl1),
    .inst_pc(inst_pc1), .inst_valid(inst_valid1), .inst_ready(rdy1),
    .jmp_en(1'b0), .jmp_addr(16'h0000)
`ifdef FETCH_ILLEGAL_TRAP_EN
    , .ill(ill1)
`endif
  );

  // ---------------- memory models ----------------
  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem1 [0:65535];
  int          lat = 1;
  bit          pend = 0;
  int          rem = 0;
  logic [15:0] paddr = 16'h0000;
  int          overlap = 0;
  logic [15:0] req_q [$];

  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (rst) begin
      pend = 0;
      req_q.delete();
    end else begin
      if (mem_req) begin
        if (pend) overlap++;
        pend  = 1;
        rem   = lat;
        paddr = mem_addr;
        req_q.push_back(mem_addr);
      end
      if (pend) begin
        rem--;
        if (rem == 0) begin
          mem_valid <= 1'b1;
          mem_rdata <= mem0[paddr];
          pend = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    mem1_valid <= 1'b0;
    if (!rst1 && mem1_req) begin
      mem1_valid <= 1'b1;
      mem1_rdata <= mem1[mem1_addr];
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input int base, input int nb, input logic [71:0] b);
    for (int i = 0; i < nb; i++) mem0[(base + i) & 16'hFFFF] = b[8*i +: 8];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem0[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    inst_ready = 1'b0;
    jmp_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!inst_valid && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          nb;
    logic [71:0] b;
    int          lat;
    logic [7:0]  eopc;
    logic [63:0] eopl;
    int          ecyc;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int cyc;
    bit ok;

    vecs.push_back('{3, 72'h03_21_04,                   1, 8'h04, 64'h0000000000000321, 6});
    vecs.push_back('{6, 72'hFF_FF_FF_FE_12_05,          1, 8'h05, 64'h000000FFFFFFFE12, 12});
    vecs.push_back('{9, 72'h08_07_06_05_04_03_02_01_06, 3, 8'h06, 64'h0807060504030201, 36});
    vecs.push_back('{6, 72'hEE_DD_CC_BB_AA_01,          2, 8'h01, 64'h000000EEDDCCBBAA, 18});
    vecs.push_back('{6, 72'h55_44_33_22_11_03,          1, 8'h03, 64'h0000005544332211, 12});
    vecs.push_back('{9, 72'h80_70_60_50_40_30_20_10_02, 1, 8'h02, 64'h8070605040302010, 18});
`ifndef FETCH_ILLEGAL_TRAP_EN
    // opc[7] has no meaning without the trap feature
    vecs.push_back('{3, 72'h12_34_84,                   1, 8'h84, 64'h0000000000001234, 6});
`endif

    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",    {63'd0, mem_req}, 64'd0);
    check("rst_mem_addr",   {48'd0, mem_addr}, 64'h0000);
    check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_opc",        {56'd0, opc}, 64'd0);
    check("rst_opl",        opl, 64'd0);
    check("rst_inst_pc",    {48'd0, inst_pc}, 64'd0);
    check("rst1_mem_addr",  {48'd0, mem1_addr}, 64'hFFFF);
    check("rst1_inst_pc",   {48'd0, inst_pc1}, 64'hFFFF);
    check("rst1_mem_req",   {63'd0, mem1_req}, 64'd0);

    // Table-driven instruction vectors
    foreach (vecs[k]) begin
      clear_mem();
      load(0, vecs[k].nb, vecs[k].b);
      lat = vecs[k].lat;
      do_reset();
      wait_valid(cyc);
      check($sformatf("v%0d_cycles", k), 64'(cyc), 64'(vecs[k].ecyc));
      check($sformatf("v%0d_opc", k), {56'd0, opc}, {56'd0, vecs[k].eopc});
      check($sformatf("v%0d_opl", k), opl, vecs[k].eopl);
      check($sformatf("v%0d_inst_pc", k), {48'd0, inst_pc}, 64'd0);
      ok = 1;
      repeat (5) begin
        @(posedge clk);
        @(negedge clk);
        if (opc !== vecs[k].eopc || opl !== vecs[k].eopl || inst_pc !== 16'h0000 ||
            inst_valid !== 1'b1 || mem_req !== 1'b0) ok = 0;
      end
      check($sformatf("v%0d_hold_stable", k), {63'd0, ok}, 64'd1);
      inst_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inst_ready = 1'b0;
      check($sformatf("v%0d_valid_drop", k), {63'd0, inst_valid}, 64'd0);
      check($sformatf("v%0d_next_req", k), {63'd0, mem_req}, 64'd1);
      check($sformatf("v%0d_next_addr", k), {48'd0, mem_addr}, 64'(vecs[k].nb));
    end

    // Jump while operand byte 2 is outstanding (3-cycle memory)
    clear_mem();
    load(0, 9, 72'h08_07_06_05_04_03_02_01_06);
    load(16'h0100, 3, 72'hA5_5A_00);
    lat = 3;
    do_reset();
    cyc = 0;
    while (req_q.size() < 4 && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("jmp_reach_byte2", 64'(req_q.size()), 64'd4);
    jmp_en = 1'b1;
    jmp_addr = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    jmp_en = 1'b0;
    check("jmp_valid_low", {63'd0, inst_valid}, 64'd0);
    check("jmp_no_req_while_drop", {63'd0, mem_req}, 64'd0);
    wait_valid(cyc);
    check("jmp_first_req_addr", (req_q.size() > 4) ? {48'd0, req_q[4]} : 64'hDEAD, 64'h0100);
    check("jmp_opc", {56'd0, opc}, 64'h00);
    check("jmp_opl", opl, 64'h000000000000A55A);
    check("jmp_inst_pc", {48'd0, inst_pc}, 64'h0100);

`ifdef FETCH_ILLEGAL_TRAP_EN
    // Illegal opcode trap
    clear_mem();
    load(0, 1, 72'h80);
    load(16'h0010, 3, 72'h22_11_00);
    lat = 1;
    do_reset();
    wait_valid(cyc);
    check("trap_ill", {63'd0, ill}, 64'd1);
    check("trap_opc", {56'd0, opc}, 64'h80);
    check("trap_opl", opl, 64'd0);
    check("trap_req_count", 64'(req_q.size()), 64'd1);
    inst_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    inst_ready = 1'b0;
    check("trap_stays_valid", {63'd0, inst_valid}, 64'd1);
    check("trap_no_more_req", 64'(req_q.size()), 64'd1);
    jmp_en = 1'b1;
    jmp_addr = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    jmp_en = 1'b0;
    check("trap_ill_cleared", {63'd0, ill}, 64'd0);
    check("trap_resume_addr", {47'd0, mem_req, mem_addr}, {47'd0, 1'b1, 16'h0010});
    wait_valid(cyc);
    check("trap_resume_pc", {48'd0, inst_pc}, 64'h0010);
    check("trap_resume_opl", opl, 64'h0000000000002211);
`endif

    // Address wrap on the RESET_PC=0xFFFF instance
    mem1[16'hFFFF] = 8'h00;
    mem1[16'h0000] = 8'hAA;
    mem1[16'h0001] = 8'hBB;
    @(negedge clk);
    rst1 = 1'b0;
    cyc = 0;
    while (!inst_valid1 && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("wrap_cycles", 64'(cyc), 64'd6);
    check("wrap_opc", {56'd0, opc1}, 64'h00);
    check("wrap_opl", opl1, 64'h000000000000BBAA);
    check("wrap_inst_pc", {48'd0, inst_pc1}, 64'hFFFF);
    rdy1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy1 = 1'b0;
    check("wrap_next_addr", {47'd0, mem1_req, mem1_addr}, {47'd0, 1'b1, 16'h0002});

    check("single_outstanding", 64'(overlap), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Byte-serial instruction fetcher; the producer end of the decoder's opc/opl interface.
- Reads variable-length instructions from byte-wide program memory and assembles the 8-bit opcode and 64-bit operand field.
- Presents one complete instruction to the decode stage under a valid/ready handshake.
- Handles redirects (jump) from the execute stage.

Parameters:
AW, 16, program-memory byte-address width
RESET_PC, 0, address of first opcode fetched after reset

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
mem_req  output  1  read request, one byte
mem_addr  output  AW  byte address of request
mem_valid  input  1  read data valid; at most one request outstanding
mem_rdata  input  8  read data byte
opc  output  8  assembled opcode to decoder
opl  output  64  assembled operand field to decoder
inst_pc  output  AW  address of opcode byte of presented instruction
inst_valid  output  1  opc/opl/inst_pc hold a complete instruction
inst_ready  input  1  decode stage accepts instruction
jmp_en  input  1  redirect request
jmp_addr  input  AW  redirect target

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high. Reset is sampled only on posedge clk.
- Reset values: mem_req=0, mem_addr=RESET_PC, opc=0, opl=0, inst_pc=RESET_PC, inst_valid=0, pc=RESET_PC, cnt=0, drop=0, state=S_OPC.
- Operand length N by opcode:
  - opc[0]=1 -> N=5 (register byte + imm32).
  - opc[1:0]=10 -> N=8 (imm64).
  - opc[1:0]=00 -> N=2 (register bytes).
- Operand assembly: operand byte k (k=0..N-1) is written to opl[8k+7:8k], little-endian. opl bytes N..7 are zero.
- Memory protocol:
  - mem_req is a 1-cycle pulse with mem_addr valid in the same cycle.
  - Next request is issued no earlier than the cycle after the mem_valid that answers the previous one.
  - Memory latency is arbitrary, >=1 cycle.
- States:
  - S_OPC: pulse mem_req at pc, go to S_OWAIT.
  - S_OWAIT: on mem_valid, latch opc=mem_rdata, inst_pc=pc, opl=0, cnt=0, pc=pc+1, go to S_OPL.
  - S_OPL: pulse mem_req at pc, go to S_LWAIT.
  - S_LWAIT: on mem_valid, write byte cnt, pc=pc+1, cnt=cnt+1. If cnt+1==N go to S_HOLD with inst_valid=1 next cycle; else go to S_OPL.
  - S_HOLD: opc/opl/inst_pc stable while inst_valid=1 and inst_ready=0. On inst_ready=1: inst_valid=0 next cycle, go to S_OPC.
- Throughput: fixed 2+2N-cycle minimum per instruction (single outstanding byte). Handshake completes in the cycle inst_valid&inst_ready.
- pc wraps modulo 2^AW; no fault on wrap.
- Jump, any state:
  - pc=jmp_addr and inst_valid=0 next cycle; state=S_OPC.
  - If a request is outstanding (S_OWAIT/S_LWAIT without mem_valid in that cycle), set drop=1.
  - While drop=1, no new request is issued. The next mem_valid is discarded and clears drop.
  - jmp_en has priority over inst_ready and mem_valid in the same cycle; the instruction being handed over is still considered accepted if inst_valid&inst_ready.
- Reset mid-operation: returns to reset values immediately. A response arriving after reset is ignored: drop is not set by rst, so the memory must be quiesced with the core.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - Opcode with opc[7]=1 is illegal. Fetcher latches opc, sets opl=0, and enters S_TRAP with inst_valid=1, with no operand fetch.
  - Extra output ill (1 bit, reset 0) is 1 while in S_TRAP.
  - inst_ready does not leave S_TRAP; only jmp_en or rst exits, clearing ill.
- Undefined: no ill port; opc[7] is ignored and the length rule applies to all opcodes.

Test Plan:
- Reset then run, 1-cycle memory; bytes at 0: 0x04,0x21,0x03 -> opc=0x04, opl=0x0000000000000321, inst_pc=0, inst_valid first high at cycle 6 after reset release; next mem_addr=3 after ready.
- Short imm: bytes 0x05,0x12,0xFE,0xFF,0xFF,0xFF -> opc=0x05, opl=0x000000FFFFFFFE12.
- imm64 with 3-cycle memory latency: 0x06 then 0x01..0x08 -> opl=0x0807060504030201. Exactly one mem_req outstanding at all times; inst_ready held low 5 cycles -> outputs stable throughout.
- Jump while waiting on operand byte 2: jmp_en, jmp_addr=0x0100 -> stale mem_valid discarded, next mem_req at 0x0100, no inst_valid from the aborted instruction.
- Wrap: RESET_PC=0xFFFF, bytes 0x00@0xFFFF, 0xAA@0x0000, 0xBB@0x0001 -> opl=0xBBAA, inst_pc=0xFFFF.
- With FETCH_ILLEGAL_TRAP_EN: opcode 0x80 -> ill=1, inst_valid=1, no further mem_req despite inst_ready=1; jmp_en to 0x0010 -> ill=0, fetch resumes at 0x0010.
